// File: rtl/fwd_operand_sel.sv
// Operand forwarding select: picks the youngest matching producer for one source
// register, raises a stall on use-before-ready and registers the operand behind valid/ready.
module fwd_operand_sel #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = $clog2(NUM_SRC + 1),
    parameter int CNT_W   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ADDR_W-1:0]          rs_addr_i,
    input  logic [DATA_W-1:0]          rf_data_i,
    input  logic [NUM_SRC-1:0]         src_wen_i,
    input  logic [NUM_SRC*ADDR_W-1:0]  src_rd_i,
    input  logic [DATA_W*NUM_SRC-1:0]  src_data_i,
    input  logic [NUM_SRC-1:0]         src_pend_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic [SEL_W-1:0]           out_sel_o,
    output logic                       stall_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    logic              hit_any;
    logic              win_pend;
    logic [DATA_W-1:0] sel_data;
    logic [SEL_W-1:0]  sel_code;
    logic              hazard;
    logic              accept;

    // First hit in ascending index order is the youngest producer; x0 never forwards.
    always_comb begin
        hit_any  = 1'b0;
        win_pend = 1'b0;
        sel_data = rf_data_i;
        sel_code = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!hit_any && src_wen_i[k] && (rs_addr_i != '0) &&
                (src_rd_i[k*ADDR_W +: ADDR_W] == rs_addr_i)) begin
                hit_any  = 1'b1;
                win_pend = src_pend_i[k];
                sel_data = src_data_i[k*DATA_W +: DATA_W];
                sel_code = SEL_W'(k + 1);
            end
        end
    end

    always_comb begin
        hazard     = in_valid_i && hit_any && win_pend;
        stall_o    = hazard && !rst_i;
        in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i;
        accept     = in_valid_i && in_ready_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_sel_o   <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            out_data_o  <= sel_data;
            out_sel_o   <= sel_code;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule
